// File: rtl/limn2600_pkg.sv
// Shared types for the Limn2600 memory adapter: access size encoding,
// adapter FSM states and the alignment rule used at request accept.
package limn2600_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    RMW_WR,
    WR,
    RESP
  } state_e;

  // A request is rejected without touching memory when its address is not
  // naturally aligned for its size, or when the size code is the illegal one.
  function automatic logic isMisaligned(input size_e size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = (lane != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/limn2600_lane_merge.sv
// Little-endian lane handling: pulls the addressed byte/half out of a memory
// word (zero-extended) and merges store data into the addressed lanes.
module limn2600_lane_merge
  import limn2600_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr,
  input  size_e       size,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  // Lanes not covered by the access keep the original memory contents.
  always_comb begin
    extracted = '0;
    merged    = word;
    case (size)
      SIZE_BYTE: begin
        extracted[7:0]                = word[{addr, 3'b000} +: 8];
        merged[{addr, 3'b000} +: 8]   = wdata[7:0];
      end
      SIZE_HALF: begin
        extracted[15:0]                  = word[{addr[1], 4'b0000} +: 16];
        merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SIZE_WORD: begin
        extracted = word;
        merged    = wdata;
      end
      default: begin
        extracted = '0;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/limn2600_mem_adapter.sv
// CPU-to-SRAM adapter: turns byte/half/word loads and stores into word
// accesses, using read-modify-write for sub-word stores, with a per-access
// ready timeout. All outputs are registered.
module limn2600_mem_adapter
  import limn2600_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rdy,
  input  logic [31:0] mem_rdata
);

  localparam int TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  state_e            r_state, w_nextState;
  logic              r_reqReady, w_reqReady;
  logic              r_memCs, w_memCs;
  logic              r_memWe, w_memWe;
  logic [31:0]       r_memAddr, w_memAddr;
  logic [31:0]       r_memWdata, w_memWdata;
  logic              r_rspValid, w_rspValid;
  logic [31:0]       r_rspRdata, w_rspRdata;
  logic              r_rspErr, w_rspErr;
  logic [TimerW-1:0] r_timer, w_timer;
  size_e             r_size, w_size;
  logic [1:0]        r_lane, w_lane;
  logic [31:0]       r_wdata, w_wdata;
  logic [31:0]       r_word, w_word;
  logic              r_err, w_err;
  logic              r_issued, w_issued;
  logic [31:0]       w_extracted;
  logic [31:0]       w_merged;

  limn2600_lane_merge u_laneMerge (
    .word      (mem_rdata),
    .wdata     (r_wdata),
    .addr      (r_lane),
    .size      (r_size),
    .extracted (w_extracted),
    .merged    (w_merged)
  );

  // Next-state and next-output logic; everything holds unless a state says otherwise.
  always_comb begin
    w_nextState = r_state;
    w_memCs     = 1'b0;
    w_memWe     = r_memWe;
    w_memAddr   = r_memAddr;
    w_memWdata  = r_memWdata;
    w_rspValid  = 1'b0;
    w_rspRdata  = '0;
    w_rspErr    = 1'b0;
    w_timer     = r_timer;
    w_size      = r_size;
    w_lane      = r_lane;
    w_wdata     = r_wdata;
    w_word      = r_word;
    w_err       = r_err;
    w_issued    = r_issued;
    case (r_state)
      IDLE: begin
        if (req_valid && r_reqReady) begin
          w_size    = size_e'(req_size);
          w_lane    = req_addr[1:0];
          w_wdata   = req_wdata;
          w_memAddr = {req_addr[31:2], 2'b00};
          w_timer   = '0;
          w_err     = 1'b0;
          w_word    = '0;
          w_issued  = 1'b0;
          if (isMisaligned(size_e'(req_size), req_addr[1:0])) begin
            w_nextState = RESP;
            w_err       = 1'b1;
          end else if (!req_we) begin
            w_nextState = RD;
            w_memCs     = 1'b1;
            w_memWe     = 1'b0;
          end else if (size_e'(req_size) == SIZE_WORD) begin
            w_nextState = WR;
            w_memCs     = 1'b1;
            w_memWe     = 1'b1;
            w_memWdata  = req_wdata;
          end else begin
            w_nextState = RMW_RD;
            w_memCs     = 1'b1;
            w_memWe     = 1'b0;
          end
        end
      end
      RD, RMW_RD, WR: begin
        if (mem_rdy) begin
          if (r_state == RD) begin
            w_word      = w_extracted;
            w_nextState = RESP;
          end else if (r_state == RMW_RD) begin
            w_word      = w_merged;
            w_issued    = 1'b0;
            w_nextState = RMW_WR;
          end else begin
            w_word      = '0;
            w_nextState = RESP;
          end
        end else if (r_timer == TimerLast) begin
          w_err       = 1'b1;
          w_word      = '0;
          w_nextState = RESP;
        end else begin
          w_timer = r_timer + TimerW'(1);
        end
      end
      RMW_WR: begin
        if (!r_issued) begin
          w_memCs    = 1'b1;
          w_memWe    = 1'b1;
          w_memWdata = r_word;
          w_timer    = '0;
          w_issued   = 1'b1;
        end else if (mem_rdy) begin
          w_word      = '0;
          w_nextState = RESP;
        end else if (r_timer == TimerLast) begin
          w_err       = 1'b1;
          w_word      = '0;
          w_nextState = RESP;
        end else begin
          w_timer = r_timer + TimerW'(1);
        end
      end
      RESP: begin
        w_rspValid  = 1'b1;
        w_rspRdata  = r_word;
        w_rspErr    = r_err;
        w_err       = 1'b0;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    w_reqReady = (w_nextState == IDLE);
  end

  // State and registered-output update; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_reqReady <= 1'b0;
      r_memCs    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
      r_timer    <= '0;
      r_size     <= SIZE_BYTE;
      r_lane     <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
      r_err      <= 1'b0;
      r_issued   <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_reqReady <= w_reqReady;
      r_memCs    <= w_memCs;
      r_memWe    <= w_memWe;
      r_memAddr  <= w_memAddr;
      r_memWdata <= w_memWdata;
      r_rspValid <= w_rspValid;
      r_rspRdata <= w_rspRdata;
      r_rspErr   <= w_rspErr;
      r_timer    <= w_timer;
      r_size     <= w_size;
      r_lane     <= w_lane;
      r_wdata    <= w_wdata;
      r_word     <= w_word;
      r_err      <= w_err;
      r_issued   <= w_issued;
    end
  end

  assign req_ready = r_reqReady;
  assign mem_cs    = r_memCs;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_limn2600_mem_adapter.sv
// Directed bench for the Limn2600 memory adapter: a vector table of single
// transactions against a small SRAM model, plus hand-written sequences for
// reset behaviour, reset mid-RMW and back-to-back loads.
module tb_limn2600_mem_adapter;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    int          mode;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expCs;
    logic [31:0] expMem;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdy;
  logic [31:0] mem_rdata;

  logic [31:0] memArr [16];
  int          rdyMode = 0;
  int          cycleCnt = 0;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs [20];

  limn2600_mem_adapter #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdy   (mem_rdy),
    .mem_rdata (mem_rdata)
  );

  // Zero-wait SRAM: mode 0 answers each chip select, mode 1 never answers,
  // mode 2 holds ready high permanently.
  assign mem_rdy   = (rdyMode == 2) ? 1'b1 : (rdyMode == 1) ? 1'b0 : mem_cs;
  assign mem_rdata = memArr[mem_addr[5:2]];

  always #5 clk = ~clk;

  // Cycle numbering used for latency measurement.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] init, input int mode,
                              input logic [31:0] expRdata, input logic expErr, input int expLat,
                              input int expCs, input logic [31:0] expMem);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.init = init; v.mode = mode;
    v.expRdata = expRdata; v.expErr = expErr; v.expLat = expLat; v.expCs = expCs; v.expMem = expMem;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request, plays the SRAM until the response and reports what was seen.
  task automatic applyStimulus(input vec_t v, output int lat, output int csCnt,
                               output logic [31:0] rdata, output logic err, output logic [31:0] csAddr);
    int accCycle;
    lat = -1; csCnt = 0; rdata = '0; err = 1'b0; csAddr = '0;
    @(negedge clk);
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
    rdyMode   = v.mode;
    req_we    = v.we;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    accCycle  = cycleCnt;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mem_cs) begin
        csCnt++;
        csAddr = mem_addr;
        if (mem_we && mem_rdy) memArr[mem_addr[5:2]] = mem_wdata;
      end
      if (rsp_valid) begin
        lat   = cycleCnt - accCycle;
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
      @(negedge clk);
    end
    rdyMode = 0;
  endtask

  // Main test sequence.
  initial begin
    int          lat, csCnt, rspIdx, accepted, violations, csSeen, rspSeen;
    logic [31:0] rdata, csAddr;
    logic        err, outstanding;

    for (int i = 0; i < 16; i++) memArr[i] = '0;

    vecs[0]  = mk(0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 3, 1, 32'hDEADBEEF);
    vecs[1]  = mk(1, 2'b00, 32'h13, 32'hAA,       32'h11223344, 0, 32'h0,        0, 5, 2, 32'hAA223344);
    vecs[2]  = mk(0, 2'b01, 32'h12, 32'h0,        32'hCAFEF00D, 0, 32'h0000CAFE, 0, 3, 1, 32'hCAFEF00D);
    vecs[3]  = mk(0, 2'b01, 32'h11, 32'h0,        32'hCAFEF00D, 0, 32'h0,        1, 2, 0, 32'hCAFEF00D);
    vecs[4]  = mk(0, 2'b00, 32'h21, 32'h0,        32'h11223344, 0, 32'h00000033, 0, 3, 1, 32'h11223344);
    vecs[5]  = mk(0, 2'b00, 32'h20, 32'h0,        32'h11223344, 0, 32'h00000044, 0, 3, 1, 32'h11223344);
    vecs[6]  = mk(0, 2'b01, 32'h24, 32'h0,        32'h8765ABCD, 0, 32'h0000ABCD, 0, 3, 1, 32'h8765ABCD);
    vecs[7]  = mk(1, 2'b01, 32'h26, 32'hFFFF5678, 32'h11223344, 0, 32'h0,        0, 5, 2, 32'h56783344);
    vecs[8]  = mk(1, 2'b00, 32'h31, 32'h12345699, 32'hAABBCCDD, 0, 32'h0,        0, 5, 2, 32'hAABB99DD);
    vecs[9]  = mk(1, 2'b10, 32'h34, 32'h0BADF00D, 32'h0,        0, 32'h0,        0, 3, 1, 32'h0BADF00D);
    vecs[10] = mk(0, 2'b10, 32'h3A, 32'h0,        32'h01020304, 0, 32'h0,        1, 2, 0, 32'h01020304);
    vecs[11] = mk(0, 2'b11, 32'h00, 32'h0,        32'h13572468, 0, 32'h0,        1, 2, 0, 32'h13572468);
    vecs[12] = mk(1, 2'b10, 32'h05, 32'hFFFFFFFF, 32'h0,        0, 32'h0,        1, 2, 0, 32'h0);
    vecs[13] = mk(1, 2'b00, 32'h0C, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        0, 5, 2, 32'hFFFFFF00);
    vecs[14] = mk(1, 2'b10, 32'h08, 32'h12345678, 32'h0,        1, 32'h0,        1, 18, 1, 32'h0);
    vecs[15] = mk(1, 2'b00, 32'h1D, 32'h77,       32'hA5A5A5A5, 1, 32'h0,        1, 18, 1, 32'hA5A5A5A5);
    vecs[16] = mk(0, 2'b10, 32'h18, 32'h0,        32'h600DF00D, 0, 32'h600DF00D, 0, 3, 1, 32'h600DF00D);
    vecs[17] = mk(0, 2'b00, 32'h2B, 32'h0,        32'h9ABCDEF0, 2, 32'h0000009A, 0, 3, 1, 32'h9ABCDEF0);
    vecs[18] = mk(1, 2'b00, 32'h2A, 32'h5A,       32'h9ABCDEF0, 2, 32'h0,        0, 5, 2, 32'h9A5ADEF0);
    vecs[19] = mk(0, 2'b01, 32'h2E, 32'h0,        32'h13579BDF, 2, 32'h00001357, 0, 3, 1, 32'h13579BDF);

    // Reset state and first ready.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h0);
    checkOutput("rst_mem_cs",    {31'b0, mem_cs},    32'h0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("rst_mem_addr",  mem_addr,           32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("release_ready_low", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    checkOutput("release_ready_high", {31'b0, req_ready}, 32'h1);

    // Table of single transactions.
    for (int i = 0; i < 20; i++) begin
      memArr[vecs[i].addr[5:2]] = vecs[i].init;
      applyStimulus(vecs[i], lat, csCnt, rdata, err, csAddr);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("v%0d_rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].expErr});
      checkOutput($sformatf("v%0d_cs_count", i), csCnt, vecs[i].expCs);
      checkOutput($sformatf("v%0d_mem", i), memArr[vecs[i].addr[5:2]], vecs[i].expMem);
      if (csCnt > 0)
        checkOutput($sformatf("v%0d_mem_addr", i), csAddr, {vecs[i].addr[31:2], 2'b00});
    end

    // Reset asserted while the RMW read is waiting.
    memArr[5] = 32'h55555555;
    @(negedge clk);
    rdyMode   = 1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h15;
    req_wdata = 32'hEE;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("midrst_cs_issued", {31'b0, mem_cs}, 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_outputs", {req_ready, mem_cs, mem_we, rsp_valid, rsp_err, 27'b0},  32'h0);
    checkOutput("midrst_mem_addr", mem_addr, 32'h0);
    checkOutput("midrst_rdata_wdata", rsp_rdata | mem_wdata, 32'h0);
    @(negedge clk);
    rdyMode = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready_low", {31'b0, req_ready}, 32'h0);
    csSeen = 0; rspSeen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("midrst_ready_high", {31'b0, req_ready}, 32'h1);
      if (mem_cs) csSeen++;
      if (rsp_valid) rspSeen++;
    end
    checkOutput("midrst_no_cs", csSeen, 0);
    checkOutput("midrst_no_rsp", rspSeen, 0);
    checkOutput("midrst_mem_kept", memArr[5], 32'h55555555);

    // Back-to-back word loads with req_valid held high.
    memArr[0] = 32'hA0A0A0A0;
    memArr[1] = 32'hB1B1B1B1;
    memArr[2] = 32'hC2C2C2C2;
    memArr[3] = 32'hD3D3D3D3;
    rspIdx = 0; accepted = 0; violations = 0; outstanding = 1'b0;
    req_we = 1'b0;
    req_size = 2'b10;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (rspIdx < 4)
          checkOutput($sformatf("b2b_rdata%0d", rspIdx), rsp_rdata, memArr[rspIdx]);
        rspIdx++;
        outstanding = 1'b0;
      end
      if (req_ready && outstanding) violations++;
      req_addr  = 32'(accepted * 4);
      req_valid = (accepted < 4);
      if (req_valid && req_ready) begin
        accepted++;
        outstanding = 1'b1;
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b_accepted", accepted, 4);
    checkOutput("b2b_rsp_count", rspIdx, 4);
    checkOutput("b2b_ready_violations", violations, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
